// File: rtl/debug_ocimem_ctrl.sv
// debug_ocimem_ctrl: JTAG bridge to single-port debug RAM, CPU port has priority.
// Define DEBUG_OCIMEM_ROM_PROTECT_EN to write-protect words 0..ROM_WORDS-1.
module debug_ocimem_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int ROM_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_readdatavalid
);
    localparam logic [1:0] IDLE = 2'd0, RD_ISSUE = 2'd1, RD_CAPT = 2'd2, WR_ISSUE = 2'd3;
    localparam logic [ADDR_W:0] LIM     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ROM_LIM = (ADDR_W+1)'(ROM_WORDS);
    logic [31:0]       mem [0:DEPTH-1];
    logic [1:0]        state;
    logic [ADDR_W-1:0] mon_a, mon_a_inc;
    logic [31:0]       wdata_q, ram_q;
    logic              cpu_act, cpu_in, cpu_rd, cpu_we, jtag_we, a_oor, a_prot, cpu_prot, busy_strobe;
    logic              unused;
    assign unused      = ^{jdo[37:36], jdo[2:0], ROM_LIM};
    assign mon_a_inc   = ({1'b0, mon_a} == LIM - 1'b1) ? '0 : mon_a + 1'b1;
    assign a_oor       = {1'b0, mon_a} >= LIM;
    assign cpu_act     = cpu_read | cpu_write;
    assign cpu_in      = {1'b0, cpu_address} < LIM;
`ifdef DEBUG_OCIMEM_ROM_PROTECT_EN
    assign a_prot      = {1'b0, mon_a} < ROM_LIM;
    assign cpu_prot    = {1'b0, cpu_address} < ROM_LIM;
`else
    assign a_prot      = 1'b0;
    assign cpu_prot    = 1'b0;
`endif
    assign cpu_rd      = cpu_read & ~cpu_write;
    assign cpu_we      = cpu_write & cpu_in & ~cpu_prot;
    assign jtag_we     = state == WR_ISSUE && !cpu_act && !a_oor && !a_prot;
    assign busy_strobe = state != IDLE && (take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b);
    // CPU and JTAG accesses are serialised, so one write port suffices
    always_ff @(posedge clk) begin
        if (cpu_we)
            mem[cpu_address] <= cpu_writedata;
        else if (jtag_we)
            mem[mon_a] <= wdata_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            mon_a             <= '0;
            wdata_q           <= '0;
            ram_q             <= '0;
            MonDReg           <= '0;
            monitor_ready     <= 1'b0;
            monitor_error     <= 1'b0;
            cpu_readdata      <= '0;
            cpu_readdatavalid <= 1'b0;
        end else begin
            cpu_readdatavalid <= cpu_rd;
            if (cpu_rd)
                cpu_readdata <= cpu_in ? mem[cpu_address] : '0;
            if ((state == RD_ISSUE || state == WR_ISSUE) && a_oor) begin
                MonDReg       <= '0;
                monitor_error <= 1'b1;
                monitor_ready <= 1'b1;
                state         <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (take_action_ocimem_a) begin
                            mon_a         <= jdo[17 +: ADDR_W];
                            monitor_error <= 1'b0;
                            monitor_ready <= ~jdo[35];
                            state         <= jdo[35] ? RD_ISSUE : IDLE;
                        end else if (take_action_ocimem_b) begin
                            wdata_q       <= jdo[34:3];
                            monitor_ready <= 1'b0;
                            state         <= WR_ISSUE;
                        end else if (take_no_action_ocimem_a) begin
                            mon_a         <= mon_a_inc;
                            monitor_ready <= 1'b0;
                            state         <= RD_ISSUE;
                        end
                    end
                    RD_ISSUE: begin
                        if (!cpu_act) begin
                            ram_q <= mem[mon_a];
                            state <= RD_CAPT;
                        end
                    end
                    RD_CAPT: begin
                        MonDReg       <= ram_q;
                        monitor_ready <= 1'b1;
                        state         <= IDLE;
                    end
                    default: begin
                        if (!cpu_act) begin
                            monitor_error <= monitor_error | a_prot;
                            mon_a         <= mon_a_inc;
                            monitor_ready <= 1'b1;
                            state         <= IDLE;
                        end
                    end
                endcase
            end
            if (busy_strobe)
                monitor_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_debug_ocimem_ctrl.sv
// tb_debug_ocimem_ctrl: randomized bench with a word-level memory model of the debug RAM.
module tb_debug_ocimem_ctrl;
`ifdef DEBUG_OCIMEM_ROM_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        ta_a = 1'b0, tna_a = 1'b0, ta_b = 1'b0;
    logic [7:0]  cpu_address = '0;
    logic        cpu_read = 1'b0, cpu_write = 1'b0;
    logic [31:0] cpu_writedata = '0;
    logic [31:0] mon_d, cpu_rd, mon_d2, cpu_rd2;
    logic        rdy, err, cpu_v, rdy2, err2, cpu_v2;
    int          checks = 0, errors = 0;
    logic [31:0] ref_mem [0:255];
    bit          ref_known [0:255];
    logic [7:0]  ref_a = '0;
    logic        ref_err = 1'b0;

    always #5 clk = ~clk;

    debug_ocimem_ctrl dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(ta_a), .take_no_action_ocimem_a(tna_a), .take_action_ocimem_b(ta_b),
        .MonDReg(mon_d), .monitor_ready(rdy), .monitor_error(err),
        .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_rd), .cpu_readdatavalid(cpu_v)
    );

    debug_ocimem_ctrl #(.DEPTH(200)) dut_small (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(ta_a), .take_no_action_ocimem_a(tna_a), .take_action_ocimem_b(ta_b),
        .MonDReg(mon_d2), .monitor_ready(rdy2), .monitor_error(err2),
        .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_rd2), .cpu_readdatavalid(cpu_v2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input logic [7:0] a, input logic rd);
        jdo = {2'b0, rd, 10'b0, a, 17'b0};
        ta_a = 1'b1;
        tick();
        ta_a = 1'b0;
        ref_a = a;
        ref_err = 1'b0;
    endtask

    task automatic pulse_write(input logic [31:0] d);
        jdo = {3'b0, d, 3'b0};
        ta_b = 1'b1;
        tick();
        ta_b = 1'b0;
    endtask

    task automatic pulse_next();
        tna_a = 1'b1;
        tick();
        tna_a = 1'b0;
        ref_a = ref_a + 8'd1;
    endtask

    task automatic wait_ready(input int max, output int n);
        n = 0;
        while (rdy !== 1'b1 && n < max) begin
            tick();
            n++;
        end
    endtask

    // JTAG write at the model address: protected words keep their value and flag an error
    task automatic ref_write(input logic [31:0] d);
        if (PROT && ref_a < 8'd64) ref_err = 1'b1;
        else begin
            ref_mem[ref_a] = d;
            ref_known[ref_a] = 1'b1;
        end
        ref_a = ref_a + 8'd1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        checks++; if (mon_d !== 32'h0) begin errors++; $display("FAIL reset_mondreg got %h exp 0", mon_d); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", rdy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_error got %b exp 0", err); end
        checks++; if (cpu_rd !== 32'h0) begin errors++; $display("FAIL reset_cpu_rd got %h exp 0", cpu_rd); end
        checks++; if (cpu_v !== 1'b0) begin errors++; $display("FAIL reset_cpu_v got %b exp 0", cpu_v); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        logic [7:0] a;
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            a = (i == 0) ? 8'h10 : 8'($urandom_range(64, 255));
            d = (i == 0) ? 32'hDEADBEEF : $urandom;
            pulse_load(a, 1'b0);
            checks++; if (rdy !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL load_done got rdy=%b err=%b exp rdy=1 err=0", rdy, err); end
            pulse_write(d);
            checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL wr_busy got %b exp 0", rdy); end
            tick();
            ref_write(d);
            checks++; if (rdy !== 1'b1 || err !== ref_err) begin errors++; $display("FAIL wr_done got rdy=%b err=%b exp rdy=1 err=%b", rdy, err, ref_err); end
            pulse_load(a, 1'b1);
            checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rd_edge1 got %b exp 0", rdy); end
            tick();
            checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rd_edge2 got %b exp 0", rdy); end
            tick();
            checks++; if (rdy !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL rd_edge3 got rdy=%b err=%b exp rdy=1 err=0", rdy, err); end
            if (ref_known[a]) begin
                checks++; if (mon_d !== ref_mem[a]) begin errors++; $display("FAIL rd_data a=%h got %h exp %h", a, mon_d, ref_mem[a]); end
            end
        end
    endtask

    task automatic test_wrap_and_range();
        logic [31:0] d;
        int n;
        pulse_load(8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            d = $urandom;
            pulse_write(d);
            tick();
            ref_write(d);
            checks++; if (rdy !== 1'b1 || err !== ref_err) begin errors++; $display("FAIL seq_wr got rdy=%b err=%b exp rdy=1 err=%b", rdy, err, ref_err); end
        end
        pulse_load(8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            pulse_next();
            wait_ready(6, n);
            checks++; if (n !== 2) begin errors++; $display("FAIL next_latency got %0d exp 2", n); end
            checks++; if (ref_a !== 8'(i)) begin errors++; $display("FAIL next_wrap_addr got %h exp %h", ref_a, 8'(i)); end
            if (ref_known[ref_a]) begin
                checks++; if (mon_d !== ref_mem[ref_a]) begin errors++; $display("FAIL next_data a=%h got %h exp %h", ref_a, mon_d, ref_mem[ref_a]); end
            end
        end
        d = $urandom;
        pulse_load(8'hD0, 1'b0);
        pulse_write(d);
        tick();
        ref_write(d);
        pulse_load(8'hD0, 1'b1);
        tick();
        checks++; if (rdy2 !== 1'b1 || err2 !== 1'b1 || mon_d2 !== 32'h0) begin errors++; $display("FAIL oor_read got rdy=%b err=%b dreg=%h exp rdy=1 err=1 dreg=0", rdy2, err2, mon_d2); end
        tick();
        checks++; if (rdy !== 1'b1 || err !== 1'b0 || mon_d !== d) begin errors++; $display("FAIL inrange_d0 got rdy=%b err=%b dreg=%h exp rdy=1 err=0 dreg=%h", rdy, err, mon_d, d); end
    endtask

    task automatic test_cpu_stall();
        logic [7:0] a;
        logic [31:0] d, last;
        int stall, n;
        for (int k = 0; k < 4; k++) begin
            a = 8'($urandom_range(64, 255));
            d = $urandom;
            stall = (k == 0) ? 4 : int'($urandom_range(1, 4));
            pulse_load(a, 1'b0);
            pulse_write(d);
            tick();
            ref_write(d);
            pulse_load(a, 1'b1);
            cpu_address = a;
            cpu_write = 1'b1;
            for (int c = 0; c < stall; c++) begin
                cpu_writedata = $urandom;
                last = cpu_writedata;
                tick();
                checks++; if (rdy !== 1'b0 || cpu_v !== 1'b0) begin errors++; $display("FAIL stall got rdy=%b cpu_v=%b exp 0 0", rdy, cpu_v); end
            end
            cpu_write = 1'b0;
            ref_mem[a] = last;
            wait_ready(8, n);
            checks++; if (n !== 2) begin errors++; $display("FAIL stall_latency got %0d exp 2", n); end
            checks++; if (mon_d !== ref_mem[a]) begin errors++; $display("FAIL stall_data got %h exp %h", mon_d, ref_mem[a]); end
            cpu_read = 1'b1;
            tick();
            cpu_read = 1'b0;
            checks++; if (cpu_v !== 1'b1 || cpu_rd !== ref_mem[a]) begin errors++; $display("FAIL cpu_rd got v=%b %h exp v=1 %h", cpu_v, cpu_rd, ref_mem[a]); end
            cpu_read = 1'b1;
            cpu_write = 1'b1;
            cpu_writedata = $urandom;
            ref_mem[a] = cpu_writedata;
            tick();
            cpu_write = 1'b0;
            checks++; if (cpu_v !== 1'b0) begin errors++; $display("FAIL cpu_rw_valid got %b exp 0", cpu_v); end
            tick();
            cpu_read = 1'b0;
            checks++; if (cpu_v !== 1'b1 || cpu_rd !== ref_mem[a]) begin errors++; $display("FAIL cpu_rw_data got v=%b %h exp v=1 %h", cpu_v, cpu_rd, ref_mem[a]); end
            tick();
            checks++; if (cpu_v !== 1'b0) begin errors++; $display("FAIL cpu_valid_pulse got %b exp 0", cpu_v); end
        end
        a = 8'($urandom_range(200, 255));
        d = $urandom;
        cpu_address = a;
        cpu_writedata = d;
        cpu_write = 1'b1;
        tick();
        cpu_write = 1'b0;
        ref_mem[a] = d;
        cpu_read = 1'b1;
        tick();
        cpu_read = 1'b0;
        checks++; if (cpu_v !== 1'b1 || cpu_rd !== d) begin errors++; $display("FAIL cpu_high got v=%b %h exp v=1 %h", cpu_v, cpu_rd, d); end
        checks++; if (cpu_v2 !== 1'b1 || cpu_rd2 !== 32'h0) begin errors++; $display("FAIL cpu_oor got v=%b %h exp v=1 0", cpu_v2, cpu_rd2); end
    endtask

    task automatic test_overrun();
        logic [7:0] a;
        logic [31:0] d, d2;
        int n;
        a = 8'($urandom_range(64, 250));
        d = $urandom;
        d2 = $urandom;
        pulse_load(a, 1'b0);
        pulse_write(d);
        tna_a = 1'b1;
        tick();
        tna_a = 1'b0;
        ref_write(d);
        checks++; if (rdy !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL overrun got rdy=%b err=%b exp 1 1", rdy, err); end
        pulse_write(d2);
        tick();
        ref_write(d2);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
        pulse_load(a, 1'b1);
        wait_ready(8, n);
        checks++; if (err !== 1'b0 || mon_d !== d) begin errors++; $display("FAIL err_clear got err=%b %h exp err=0 %h", err, mon_d, d); end
        pulse_load(a + 8'd1, 1'b1);
        wait_ready(8, n);
        checks++; if (mon_d !== d2) begin errors++; $display("FAIL overrun_no_inc got %h exp %h", mon_d, d2); end
        jdo = {2'b0, 1'b1, 10'b0, a, 17'b0};
        ta_a = 1'b1;
        ta_b = 1'b1;
        tna_a = 1'b1;
        tick();
        {ta_a, ta_b, tna_a} = 3'b0;
        ref_a = a;
        wait_ready(8, n);
        checks++; if (n !== 2 || mon_d !== d || err !== 1'b0) begin errors++; $display("FAIL priority got n=%0d %h err=%b exp n=2 %h err=0", n, mon_d, err, d); end
        pulse_next();
        wait_ready(8, n);
        checks++; if (mon_d !== ref_mem[ref_a]) begin errors++; $display("FAIL priority_b_dropped got %h exp %h", mon_d, ref_mem[ref_a]); end
    endtask

    task automatic test_rom_protect();
        int n;
        pulse_load(8'd5, 1'b0);
        pulse_write(32'h12345678);
        tick();
        ref_write(32'h12345678);
        checks++; if (rdy !== 1'b1 || err !== ref_err) begin errors++; $display("FAIL rom_wr got rdy=%b err=%b exp rdy=1 err=%b", rdy, err, ref_err); end
        pulse_load(8'd5, 1'b1);
        wait_ready(8, n);
        checks++; if ((mon_d === 32'h12345678) !== ref_known[5]) begin errors++; $display("FAIL rom_readback got %h writable=%b", mon_d, ref_known[5]); end
        cpu_address = 8'd6;
        cpu_writedata = 32'hCAFEF00D;
        cpu_write = 1'b1;
        tick();
        cpu_write = 1'b0;
        cpu_read = 1'b1;
        tick();
        cpu_read = 1'b0;
        checks++; if ((cpu_rd === 32'hCAFEF00D) !== !PROT) begin errors++; $display("FAIL rom_cpu got %h protect=%b", cpu_rd, PROT); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] a;
        logic [31:0] w;
        int n;
        a = PROT ? 8'd100 : 8'd0;
        w = $urandom | 32'h1;
        pulse_load(a, 1'b0);
        pulse_write(w);
        tick();
        ref_write(w);
        pulse_load(a, 1'b1);
        wait_ready(8, n);
        pulse_load(a, 1'b1);
        cpu_address = a;
        cpu_read = 1'b1;
        tna_a = 1'b1;
        tick();
        tna_a = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++; if ({mon_d, rdy, err, cpu_rd, cpu_v} !== '0) begin errors++; $display("FAIL reset_mid got dreg=%h rdy=%b err=%b cpu=%h v=%b exp all 0", mon_d, rdy, err, cpu_rd, cpu_v); end
        cpu_read = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        pulse_load(a, 1'b0);
        pulse_write(~w);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        pulse_load(a, 1'b1);
        wait_ready(8, n);
        checks++; if (n !== 2 || mon_d !== w) begin errors++; $display("FAIL reset_retain got n=%0d %h exp n=2 %h", n, mon_d, w); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wrap_and_range();
        test_cpu_stall();
        test_overrun();
        test_rom_protect();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
